// File: rtl/rtc_bus_responder.sv
// Real-time clock with a countdown timer, accessed over an asynchronous
// multiplexed address/data bus. All bus inputs are resynchronised before use.
module rtc_bus_responder #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CS,
   input  logic       AD,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       irq
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [1:0]    r_cs_sy, r_ad_sy, r_rd_sy, r_wr_sy;
   logic [7:0]    r_din_s1, r_din_s2;
   logic          r_wr_d;
   logic [1:0]    r_vld;
   logic          r_arm;
   logic [7:0]    r_ptr;
   logic [PW-1:0] r_pre;
   logic [7:0]    r_sec, r_min, r_hour, r_day, r_mon, r_year;
   logic [7:0]    r_tsec, r_tmin, r_thr;
   logic          r_irq;
   logic [7:0]    r_dout;
   logic          r_oe;

   logic       w_cs, w_ad, w_rd, w_wr;
   logic       w_wr_evt, w_addr_wr, w_data_wr, w_oe, w_tick, w_run;
   logic       w_wr_sec, w_wr_min, w_wr_hour, w_wr_day, w_wr_mon, w_wr_year;
   logic       w_wr_tsec, w_wr_tmin, w_wr_thr, w_wr_stat;
   logic       w_c_sec, w_c_min, w_c_hour, w_c_day, w_c_mon;
   logic       w_b_sec, w_b_min;
   logic [7:0] w_sec_n, w_min_n, w_hour_n, w_day_n, w_mon_n, w_year_n;
   logic [7:0] w_tsec_n, w_tmin_n, w_thr_n, w_rd_data;
   logic       w_irq_set, w_irq_n;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax,
                                          input logic [7:0] vmin);
      if (v == vmax)             return vmin;
      else if (v[3:0] == 4'h9)   return {v[7:4] + 4'h1, 4'h0};
      else                       return {v[7:4], v[3:0] + 4'h1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
      if (v == 8'h00)            return vmax;
      else if (v[3:0] == 4'h0)   return {v[7:4] - 4'h1, 4'h9};
      else                       return {v[7:4], v[3:0] - 4'h1};
   endfunction

   assign w_cs = r_cs_sy[1];
   assign w_ad = r_ad_sy[1];
   assign w_rd = r_rd_sy[1];
   assign w_wr = r_wr_sy[1];

   // WR edges only count once WR has genuinely been seen high since reset
   assign w_wr_evt  = r_arm & w_wr & ~r_wr_d & ~w_cs;
   assign w_addr_wr = w_wr_evt & ~w_ad;
   assign w_data_wr = w_wr_evt & w_ad;
   assign w_oe      = ~w_cs & ~w_rd & w_ad & w_wr;

   assign w_wr_sec  = w_data_wr & (r_ptr == 8'h21);
   assign w_wr_min  = w_data_wr & (r_ptr == 8'h22);
   assign w_wr_hour = w_data_wr & (r_ptr == 8'h23);
   assign w_wr_day  = w_data_wr & (r_ptr == 8'h24);
   assign w_wr_mon  = w_data_wr & (r_ptr == 8'h25);
   assign w_wr_year = w_data_wr & (r_ptr == 8'h26);
   assign w_wr_tsec = w_data_wr & (r_ptr == 8'h41);
   assign w_wr_tmin = w_data_wr & (r_ptr == 8'h42);
   assign w_wr_thr  = w_data_wr & (r_ptr == 8'h43);
   assign w_wr_stat = w_data_wr & (r_ptr == 8'h00);

   assign w_tick = (r_pre == PW'(TICK_DIV - 1));
   assign w_run  = w_tick & (|{r_tsec, r_tmin, r_thr});

   // A bus write to a register swallows that register's carry/borrow
   assign w_c_sec  = w_tick   & (r_sec  == 8'h59) & ~w_wr_sec;
   assign w_c_min  = w_c_sec  & (r_min  == 8'h59) & ~w_wr_min;
   assign w_c_hour = w_c_min  & (r_hour == 8'h23) & ~w_wr_hour;
   assign w_c_day  = w_c_hour & (r_day  == 8'h31) & ~w_wr_day;
   assign w_c_mon  = w_c_day  & (r_mon  == 8'h12) & ~w_wr_mon;
   assign w_b_sec  = w_run    & (r_tsec == 8'h00) & ~w_wr_tsec;
   assign w_b_min  = w_b_sec  & (r_tmin == 8'h00) & ~w_wr_tmin;

   always_comb begin
      w_sec_n  = r_sec;
      w_min_n  = r_min;
      w_hour_n = r_hour;
      w_day_n  = r_day;
      w_mon_n  = r_mon;
      w_year_n = r_year;
      w_tsec_n = r_tsec;
      w_tmin_n = r_tmin;
      w_thr_n  = r_thr;
      if (w_wr_sec)       w_sec_n  = r_din_s2;
      else if (w_tick)    w_sec_n  = bcd_inc(r_sec, 8'h59, 8'h00);
      if (w_wr_min)       w_min_n  = r_din_s2;
      else if (w_c_sec)   w_min_n  = bcd_inc(r_min, 8'h59, 8'h00);
      if (w_wr_hour)      w_hour_n = r_din_s2;
      else if (w_c_min)   w_hour_n = bcd_inc(r_hour, 8'h23, 8'h00);
      if (w_wr_day)       w_day_n  = r_din_s2;
      else if (w_c_hour)  w_day_n  = bcd_inc(r_day, 8'h31, 8'h01);
      if (w_wr_mon)       w_mon_n  = r_din_s2;
      else if (w_c_day)   w_mon_n  = bcd_inc(r_mon, 8'h12, 8'h01);
      if (w_wr_year)      w_year_n = r_din_s2;
      else if (w_c_mon)   w_year_n = bcd_inc(r_year, 8'h99, 8'h00);
      if (w_wr_tsec)      w_tsec_n = r_din_s2;
      else if (w_run)     w_tsec_n = bcd_dec(r_tsec, 8'h59);
      if (w_wr_tmin)      w_tmin_n = r_din_s2;
      else if (w_b_sec)   w_tmin_n = bcd_dec(r_tmin, 8'h59);
      if (w_wr_thr)       w_thr_n  = r_din_s2;
      else if (w_b_min)   w_thr_n  = bcd_dec(r_thr, 8'h23);
      w_irq_set = w_run & (w_tsec_n == 8'h00) & (w_tmin_n == 8'h00) & (w_thr_n == 8'h00);
      w_irq_n   = (r_irq & ~w_wr_stat) | w_irq_set;
   end

   always_comb begin
      case (r_ptr)
         8'h00:   w_rd_data = {7'b0, r_irq};
         8'h21:   w_rd_data = r_sec;
         8'h22:   w_rd_data = r_min;
         8'h23:   w_rd_data = r_hour;
         8'h24:   w_rd_data = r_day;
         8'h25:   w_rd_data = r_mon;
         8'h26:   w_rd_data = r_year;
         8'h41:   w_rd_data = r_tsec;
         8'h42:   w_rd_data = r_tmin;
         8'h43:   w_rd_data = r_thr;
         default: w_rd_data = 8'h00;
      endcase
   end

   // Input synchronisers and write-edge qualification
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs_sy  <= 2'b11;
         r_ad_sy  <= 2'b00;
         r_rd_sy  <= 2'b11;
         r_wr_sy  <= 2'b11;
         r_din_s1 <= 8'h00;
         r_din_s2 <= 8'h00;
         r_wr_d   <= 1'b1;
         r_vld    <= 2'b00;
         r_arm    <= 1'b0;
      end else begin
         r_cs_sy  <= {r_cs_sy[0], CS};
         r_ad_sy  <= {r_ad_sy[0], AD};
         r_rd_sy  <= {r_rd_sy[0], RD};
         r_wr_sy  <= {r_wr_sy[0], WR};
         r_din_s1 <= data_in;
         r_din_s2 <= r_din_s1;
         r_wr_d   <= w_wr;
         r_vld    <= {r_vld[0], 1'b1};
         r_arm    <= r_arm | (r_vld[1] & w_wr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr  <= 8'h00;
         r_pre  <= '0;
         r_sec  <= 8'h00;
         r_min  <= 8'h00;
         r_hour <= 8'h00;
         r_day  <= 8'h01;
         r_mon  <= 8'h01;
         r_year <= 8'h00;
         r_tsec <= 8'h00;
         r_tmin <= 8'h00;
         r_thr  <= 8'h00;
         r_irq  <= 1'b0;
         r_dout <= 8'h00;
         r_oe   <= 1'b0;
      end else begin
         if (w_addr_wr) r_ptr <= r_din_s2;
         r_pre  <= w_tick ? '0 : r_pre + PW'(1);
         r_sec  <= w_sec_n;
         r_min  <= w_min_n;
         r_hour <= w_hour_n;
         r_day  <= w_day_n;
         r_mon  <= w_mon_n;
         r_year <= w_year_n;
         r_tsec <= w_tsec_n;
         r_tmin <= w_tmin_n;
         r_thr  <= w_thr_n;
         r_irq  <= w_irq_n;
         r_oe   <= w_oe;
         r_dout <= w_oe ? w_rd_data : 8'h00;
      end
   end

   assign data_out = r_dout;
   assign data_oe  = r_oe;
   assign irq      = r_irq;
endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 Parameter: TICK_DIV, default 100000000, clk cycles per one-second tick.
REQ-002 Ports (name, direction, width, meaning):
- clk  input  1  system clock; the block uses one clock.
- reset  input  1  asynchronous, active-high reset.
- CS  input  1  chip select, active-low.
- AD  input  1  phase select: 0 = address phase, 1 = data phase.
- RD  input  1  read strobe, active-low.
- WR  input  1  write strobe, active-low.
- data_in  input  8  bus value driven by the initiator.
- data_out  output  8  read data returned to the initiator.
- data_oe  output  1  bus drive enable; 1 = responder drives the bus.
- irq  output  1  timer-expiry interrupt, active-high, level.

Function
REQ-003 CS, AD, RD, WR and data_in SHALL each pass through a 2-flop synchronizer; all decoding SHALL use the synchronized copies.
REQ-004 Write event: a synchronized WR rising edge while synchronized CS=0; the event SHALL be detected one cycle after the second synchronizer stage.
REQ-005 Write event with AD=0 SHALL load data_in into the 8-bit address pointer; registers unchanged.
REQ-006 Write event with AD=1 SHALL write data_in into the register at the address pointer; the pointer SHALL NOT auto-increment.
REQ-007 Register map (BCD): 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 timer sec, 0x42 timer min, 0x43 timer hour, 0x00 status (bit0 = irq flag, bits7:1 read 0).
REQ-008 Unmapped addresses SHALL read 0x00; writes to them SHALL be ignored.
REQ-009 Any data write to 0x00 SHALL clear the irq flag regardless of the value written.
REQ-010 data_oe SHALL be 1 exactly while synchronized CS=0, RD=0, AD=1 and WR=1; otherwise it SHALL be 0.
REQ-011 data_out SHALL be registered, equal to the register at the pointer while data_oe=1, and 0x00 otherwise.
REQ-012 If synchronized RD=0 and WR=0 together, the block SHALL treat the cycle as write-only, with data_oe=0.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle tick on wrap.
REQ-014 On tick, the clock chain SHALL increment in BCD:
- sec and min: 0x59 -> 0x00 with carry.
- hour: 0x23 -> 0x00 with carry.
- day: 0x31 -> 0x01 with carry.
- month: 0x12 -> 0x01 with carry.
- year: 0x99 -> 0x00, no carry out.
REQ-015 On tick, if the timer (hr:min:sec) is nonzero, it SHALL decrement in BCD with borrow (sec/min 0x00 -> 0x59); a zero timer SHALL hold at zero.
REQ-016 When the timer decrements to 00:00:00, the irq flag SHALL set on the same tick.
REQ-017 The irq flag SHALL stay set until cleared by REQ-009 or by reset.
REQ-018 irq SHALL equal the irq flag, registered.
REQ-019 If a bus data write and a tick hit the same register in the same cycle, the bus write SHALL win and that register's carry/borrow SHALL be suppressed for that tick.
REQ-020 Non-BCD values written SHALL be stored as written; the increment/decrement logic SHALL follow the same rules applied to each nibble, with no range checking.

Reset
REQ-021 On reset the following SHALL clear to 0:
- synchronizers (CS, RD, WR to 1), address pointer, prescaler, irq flag;
- sec, min, hour, year and the timer registers;
- outputs: data_out=0x00, data_oe=0, irq=0.
REQ-022 On reset, day and month SHALL load 0x01.
REQ-023 Reset asserted mid-transaction SHALL abort it with no register write, and the next WR edge SHALL NOT be detected until WR has been seen high after reset.

Verification
REQ-024 Address write 0x21 then data write 0x45 (AD=1); read with RD=0 -> data_oe=1, data_out=0x45 within 4 cycles of RD falling.
REQ-025 TICK_DIV=4; time preset 23:59:59, day 0x31, month 0x12, year 0x99; one tick -> 00:00:00, day 0x01, month 0x01, year 0x00.
REQ-026 Timer preset 00:00:02, TICK_DIV=4 -> irq rises on the 2nd tick and the timer holds at 00:00:00; data write to 0x00 -> irq=0 three to four cycles later.
REQ-027 Read from address 0x30 -> data_out=0x00; write 0x77 to 0x30, then read 0x21 -> 0x21 value unchanged.
REQ-028 Data write of 0x10 to sec coinciding with a tick while sec=0x59 -> sec=0x10 and min unchanged.
REQ-029 Reset pulsed while WR=0 during a data phase -> no register change, all outputs at reset values.
